// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and its instruction RAM.
package prog_loader_pkg;

  // Loader FSM encoding; kept as plain constants so older tools and
  // checkers can match on raw 3-bit values.
  localparam logic [2:0] HDR_HI  = 3'd0;
  localparam logic [2:0] HDR_LO  = 3'd1;
  localparam logic [2:0] DATA_HI = 3'd2;
  localparam logic [2:0] DATA_LO = 3'd3;
  localparam logic [2:0] CHK     = 3'd4;
  localparam logic [2:0] RUN     = 3'd5;
  localparam logic [2:0] ERR     = 3'd6;

  localparam int          BYTES_PER_WORD = 2;
  localparam logic [15:0] NOP_INSTR      = 16'h0000;

endpackage

// File: rtl/prog_loader_imem_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module imem_ram #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [2**ADDR_W];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Program loader: accepts a big-endian byte stream (count, words, XOR
// checksum), fills instruction RAM, then releases the core from reset and
// serves instructions addressed by the core's PC.
//
// Handshake: a byte is transferred on a rising edge where in_valid and
// in_ready are both 1; in_valid may drop at any time and the FSM simply
// waits. in_ready depends only on state, never on in_valid.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = BYTES_PER_WORD * 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               load_req,
  input  logic [15:0]        pc,
  output logic [INSTR_W-1:0] instr,
  output logic               cpu_rst,
  output logic               loaded,
  output logic               err,
  output logic [ADDR_W:0]    words_loaded,
  output logic [2:0]         dbg_state
);

  localparam int         WL_W    = ADDR_W + 1;
  localparam logic [16:0] DEPTH_N = 17'(2**ADDR_W);

  logic [2:0]         state, state_n;
  logic [7:0]         count_hi;
  logic [15:0]        count;
  logic [7:0]         hi_byte;
  logic [7:0]         xor_acc;
  logic               fire;
  logic               we;
  logic [15:0]        n_hdr;
  logic [WL_W-1:0]    wl_next;
  logic [15:0]        wl_next16;
  logic [INSTR_W-1:0] rdata;

  assign in_ready  = (state != RUN) && (state != ERR);
  assign fire      = in_valid && in_ready;
  assign n_hdr     = {count_hi, in_data};
  assign wl_next   = words_loaded + WL_W'(1);
  assign wl_next16 = 16'(wl_next);
  assign err       = (state == ERR);
  assign dbg_state = state;

  // Next-state decode and RAM write strobe
  always_comb begin
    state_n = state;
    we      = 1'b0;
    case (state)
      HDR_HI:  if (fire) state_n = HDR_LO;
      HDR_LO:  if (fire) begin
        if (n_hdr == 16'd0)              state_n = CHK;
        else if ({1'b0, n_hdr} > DEPTH_N) state_n = ERR;
        else                             state_n = DATA_HI;
      end
      DATA_HI: if (fire) state_n = DATA_LO;
      DATA_LO: if (fire) begin
        we      = 1'b1;
        state_n = (wl_next16 == count) ? CHK : DATA_HI;
      end
      CHK:     if (fire) state_n = (in_data == xor_acc) ? RUN : ERR;
      RUN, ERR: if (load_req) state_n = HDR_HI;
      default: state_n = HDR_HI;
    endcase
  end

  // State register plus registered core-control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HDR_HI;
      cpu_rst <= 1'b1;
      loaded  <= 1'b0;
    end else begin
      state   <= state_n;
      cpu_rst <= (state_n != RUN);
      loaded  <= (state_n == RUN);
    end
  end

  // Header, hi-byte, running checksum and word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_hi     <= 8'd0;
      count        <= 16'd0;
      hi_byte      <= 8'd0;
      xor_acc      <= 8'd0;
      words_loaded <= '0;
    end else if (fire) begin
      case (state)
        HDR_HI: begin
          count_hi     <= in_data;
          xor_acc      <= in_data;
          words_loaded <= '0;
        end
        HDR_LO: begin
          count   <= n_hdr;
          xor_acc <= xor_acc ^ in_data;
        end
        DATA_HI: begin
          hi_byte <= in_data;
          xor_acc <= xor_acc ^ in_data;
        end
        DATA_LO: begin
          xor_acc      <= xor_acc ^ in_data;
          words_loaded <= wl_next;
        end
        default: ;
      endcase
    end
  end

  imem_ram #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (words_loaded[ADDR_W-1:0]),
    .wdata ({hi_byte, in_data}),
    .raddr (pc[ADDR_W-1:0]),
    .rdata (rdata)
  );

  // Addresses beyond the RAM read as NOP
  assign instr = (|pc[15:ADDR_W]) ? NOP_INSTR : rdata;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: byte-stream driver, scoreboard queues for status and
// instruction checks, and an array model of the instruction RAM.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        load_req = 1'b0;
  logic [15:0] pc = 16'd0;
  logic [15:0] instr;
  logic        cpu_rst, loaded, err;
  logic [8:0]  words_loaded;
  logic [2:0]  dbg_state;

  prog_loader #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .load_req(load_req), .pc(pc), .instr(instr),
    .cpu_rst(cpu_rst), .loaded(loaded), .err(err),
    .words_loaded(words_loaded), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int vectors = 0;
  int miscompares = 0;
  logic [12:0] stat_q[$];   // {in_ready, cpu_rst, loaded, err, words_loaded}
  logic [15:0] exp_q[$];    // expected instr
  logic        chk_stat = 1'b0;
  logic        chk_instr = 1'b0;

  // Reference model
  logic [15:0] mem_model[256];
  bit          written[256];
  logic [15:0] load_words[$];
  logic [8:0]  model_wl = 9'd0;

  always @(negedge clk) begin
    logic [12:0] es;
    logic [15:0] ei;
    if (chk_stat) begin
      vectors++;
      if (stat_q.size() == 0) begin
        miscompares++;
        $display("FAIL status: no expected entry queued");
      end else begin
        es = stat_q.pop_front();
        if ({in_ready, cpu_rst, loaded, err, words_loaded} !== es) begin
          miscompares++;
          $display("FAIL status t=%0t got rdy=%b cpu_rst=%b loaded=%b err=%b wl=%0d exp rdy=%b cpu_rst=%b loaded=%b err=%b wl=%0d",
                   $time, in_ready, cpu_rst, loaded, err, words_loaded,
                   es[12], es[11], es[10], es[9], es[8:0]);
        end
      end
    end
    if (chk_instr) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL instr: no expected entry queued");
      end else begin
        ei = exp_q.pop_front();
        if (instr !== ei) begin
          miscompares++;
          $display("FAIL instr pc=%0d got=%h exp=%h", pc, instr, ei);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_stat(input logic rdy, input logic crst, input logic ld,
                            input logic er, input logic [8:0] wl);
    stat_q.push_back({rdy, crst, ld, er, wl});
    chk_stat = 1'b1;
    tick();
    chk_stat = 1'b0;
  endtask

  task automatic check_instr(input logic [15:0] addr);
    logic [15:0] e;
    if (addr >= 16'd256) e = 16'h0000;
    else                 e = mem_model[addr[7:0]];
    pc = addr;
    exp_q.push_back(e);
    chk_instr = 1'b1;
    tick();
    chk_instr = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc = 1'b0;
    int waited = 0;
    int g = 0;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1 && g < 8) begin
        in_valid = 1'b0;
        tick();
        g++;
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      waited++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_accept: byte %h not taken within 50 cycles", b);
    end
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    // cpu_rst must already be high after that single edge
    check_stat(1'b1, 1'b1, 1'b0, 1'b0, model_wl);
  endtask

  // Streams an image of n words (load_words supplies them, random fill
  // otherwise); corrupt flips bit 0 of the checksum.
  task automatic run_load(input int n, input bit corrupt, input bit gaps);
    logic [7:0]  bq[$];
    logic [7:0]  chk = 8'd0;
    logic [15:0] nn = 16'(n);
    bit          oversize = (n > 256);
    bq.push_back(nn[15:8]);
    bq.push_back(nn[7:0]);
    if (!oversize) begin
      while (load_words.size() < n) load_words.push_back(16'($urandom()));
      for (int i = 0; i < n; i++) begin
        bq.push_back(load_words[i][15:8]);
        bq.push_back(load_words[i][7:0]);
      end
    end
    foreach (bq[i]) chk = chk ^ bq[i];
    if (corrupt) chk = chk ^ 8'h01;

    if (oversize) begin
      send_byte(bq[0], gaps);
      send_byte(bq[1], gaps);
      model_wl = 9'd0;
      check_stat(1'b0, 1'b1, 1'b0, 1'b1, model_wl);
    end else begin
      foreach (bq[i]) send_byte(bq[i], gaps);
      for (int i = 0; i < n; i++) begin
        mem_model[i] = load_words[i];
        written[i]   = 1'b1;
      end
      model_wl = 9'(n);
      // waiting for the checksum byte
      check_stat(1'b1, 1'b1, 1'b0, 1'b0, model_wl);
      send_byte(chk, 1'b0);
      // observed the cycle after the checksum edge
      if (corrupt) check_stat(1'b0, 1'b1, 1'b0, 1'b1, model_wl);
      else         check_stat(1'b0, 1'b0, 1'b1, 1'b0, model_wl);
    end
    load_words.delete();
  endtask

  task automatic verify_ram();
    for (int a = 0; a < 256; a++)
      if (written[a]) check_instr(16'(a));
    check_instr(16'd256);
    check_instr(16'd300);
    check_instr(16'($urandom_range(257, 65535)));
  endtask

  task automatic offer_idle_bytes();
    in_data  = 8'($urandom());
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
  endtask

  // Stimulus
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_stat(1'b1, 1'b1, 1'b0, 1'b0, 9'd0);

    // Good load with the fixed three-word image
    load_words = '{16'h1234, 16'h5678, 16'h9ABC};
    run_load(3, 1'b0, 1'b0);
    check_instr(16'd1);
    check_instr(16'd300);
    verify_ram();
    offer_idle_bytes();
    check_stat(1'b0, 1'b0, 1'b1, 1'b0, model_wl);

    // Bad checksum, then recover
    pulse_load_req();
    load_words = '{16'h1234, 16'h5678, 16'h9ABC};
    run_load(3, 1'b1, 1'b0);
    offer_idle_bytes();
    check_stat(1'b0, 1'b1, 1'b0, 1'b1, model_wl);
    pulse_load_req();
    load_words = '{16'h1234, 16'h5678, 16'h9ABC};
    run_load(3, 1'b0, 1'b0);
    verify_ram();

    // Reset in the middle of a stream
    pulse_load_req();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h12, 1'b0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_wl = 9'd0;
    check_stat(1'b1, 1'b1, 1'b0, 1'b0, 9'd0);

    // Oversize header goes straight to ERR and writes nothing
    run_load(257, 1'b0, 1'b0);
    verify_ram();
    pulse_load_req();

    // Empty image
    run_load(0, 1'b0, 1'b0);
    pulse_load_req();

    // Random small images
    for (int k = 0; k < 3; k++) begin
      run_load($urandom_range(1, 20), 1'b0, 1'b1);
      verify_ram();
      pulse_load_req();
    end

    // Full RAM with backpressure gaps
    run_load(256, 1'b0, 1'b1);
    verify_ram();

    // Reload overwrites word 0
    pulse_load_req();
    run_load(1, 1'b0, 1'b0);
    check_instr(16'd0);
    check_instr(16'd1);

    repeat (2) tick();
    if (stat_q.size() != 0 || exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d status and %0d instr entries left", stat_q.size(), exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
